// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types for the traffic phase controller.
//   state_t  - phase sequencer states
//   phase_t  - which GO phase (A = N/S lower lanes, B = E/W upper lanes)
//   MODE_*   - mode output encodings (emergency/pedestrian/night/day)
//   mode_of  - maps a sequencer state to its mode encoding
package traffic_pkg;

  typedef enum logic [3:0] {
    A_GO,
    A_CLR,
    B_GO,
    B_CLR,
    PED_WALK,
    PED_CLR,
    PRE_CLR,
    EMG,
    EMG_CLR,
    NIGHT
  } state_t;

  typedef enum logic {
    PHASE_A,
    PHASE_B
  } phase_t;

  localparam logic [1:0] MODE_EMG   = 2'd0;
  localparam logic [1:0] MODE_PED   = 2'd1;
  localparam logic [1:0] MODE_NIGHT = 2'd2;
  localparam logic [1:0] MODE_DAY   = 2'd3;

  function automatic logic [1:0] mode_of(state_t s);
    case (s)
      PRE_CLR, EMG, EMG_CLR: return MODE_EMG;
      PED_WALK, PED_CLR:     return MODE_PED;
      NIGHT:                 return MODE_NIGHT;
      default:               return MODE_DAY;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// traffic_phase_controller_if: request inputs and light/walk/mode outputs of
// the intersection controller.
//   time_signal, ped_signal, emg_signal, emg_lane : requests into the controller
//   light_out, walk_out, flash_out, mode          : registered controller outputs
//   walk_remaining                                : walk countdown, present only
//                                                   with TRAFFIC_WALK_COUNTDOWN_EN
// Modports: master = requester / light driver side, slave = controller.
interface traffic_phase_controller_if #(
  parameter int unsigned LANES = 8
`ifdef TRAFFIC_WALK_COUNTDOWN_EN
  , parameter int unsigned CNT_W = 8
`endif
);

  logic             time_signal;
  logic             ped_signal;
  logic             emg_signal;
  logic [LANES-1:0] emg_lane;
  logic [LANES-1:0] light_out;
  logic [LANES-1:0] walk_out;
  logic             flash_out;
  logic [1:0]       mode;
`ifdef TRAFFIC_WALK_COUNTDOWN_EN
  logic [CNT_W-1:0] walk_remaining;
`endif

  modport master (
    output time_signal, ped_signal, emg_signal, emg_lane,
    input  light_out, walk_out, flash_out, mode
`ifdef TRAFFIC_WALK_COUNTDOWN_EN
    , input walk_remaining
`endif
  );

  modport slave (
    input  time_signal, ped_signal, emg_signal, emg_lane,
    output light_out, walk_out, flash_out, mode
`ifdef TRAFFIC_WALK_COUNTDOWN_EN
    , output walk_remaining
`endif
  );

endinterface

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that stops at zero.
//   clk, rst   : clock, asynchronous active-low reset (value = RST_VAL)
//   load       : load load_value this cycle (takes priority over counting)
//   load_value : value to load
//   value      : current count
//   expire     : high while value == 1, i.e. on the last cycle of the interval
module phase_timer #(
  parameter int unsigned    CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             expire
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expire = (value == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: timed phase sequencer for an intersection with
// all-red clearance, emergency preemption with lane latching, queued
// pedestrian requests and a night flash mode.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : traffic_phase_controller_if.slave (requests in, lights/walk/mode out)
// Optional: TRAFFIC_WALK_COUNTDOWN_EN adds bus.walk_remaining (timer value
// during PED_WALK, 0 elsewhere).
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned LANES        = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_CYCLES = 16,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned WALK_CYCLES  = 12,
  parameter int unsigned FLASH_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  traffic_phase_controller_if.slave    bus
);

  localparam logic [LANES-1:0] LOW_MASK  = {{(LANES/2){1'b0}}, {(LANES/2){1'b1}}};
  localparam logic [LANES-1:0] HIGH_MASK = ~LOW_MASK;

  localparam logic [CNT_W-1:0] T_GREEN = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] T_CLEAR = CNT_W'(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] T_WALK  = CNT_W'(WALK_CYCLES);
  localparam logic [CNT_W-1:0] T_FLASH = CNT_W'(FLASH_CYCLES);

  state_t           state;
  state_t           nxt;
  state_t           clr_exit;
  phase_t           last_phase;
  logic             ped_pending;
  logic             ped_req;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;

  logic             flash_load;
  logic [CNT_W-1:0] flash_val;
  logic             flash_exp;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (T_CLEAR)
  ) u_state_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_load_val),
    .value      (tmr_val),
    .expire     (tmr_exp)
  );

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL ('0)
  ) u_flash_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (flash_load),
    .load_value (T_FLASH),
    .value      (flash_val),
    .expire     (flash_exp)
  );

  // A request arriving on the very cycle a clearance ends is honoured too.
  assign ped_req = ped_pending | bus.ped_signal;

  always_comb begin
    if (bus.emg_signal) begin
      clr_exit = EMG;
    end else if (ped_req) begin
      clr_exit = PED_WALK;
    end else if (bus.time_signal) begin
      clr_exit = NIGHT;
    end else if (last_phase == PHASE_A) begin
      clr_exit = B_GO;
    end else begin
      clr_exit = A_GO;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      A_GO: begin
        if (bus.emg_signal)   nxt = PRE_CLR;
        else if (tmr_exp)     nxt = A_CLR;
      end
      B_GO: begin
        if (bus.emg_signal)   nxt = PRE_CLR;
        else if (tmr_exp)     nxt = B_CLR;
      end
      PED_WALK: begin
        if (bus.emg_signal)   nxt = PRE_CLR;
        else if (tmr_exp)     nxt = PED_CLR;
      end
      NIGHT: begin
        if (bus.emg_signal)       nxt = PRE_CLR;
        else if (ped_req)         nxt = PED_WALK;
        else if (!bus.time_signal) nxt = B_CLR;
      end
      EMG: begin
        if (!bus.emg_signal)  nxt = EMG_CLR;
      end
      A_CLR, B_CLR, PED_CLR, PRE_CLR, EMG_CLR: begin
        if (tmr_exp)          nxt = clr_exit;
      end
      default:                nxt = B_CLR;
    endcase
  end

  // Every state change is an entry into a new state; EMG and NIGHT are
  // untimed so whatever they load is simply ignored.
  always_comb begin
    tmr_load = (nxt != state);
    case (nxt)
      A_GO, B_GO: tmr_load_val = T_GREEN;
      PED_WALK:   tmr_load_val = T_WALK;
      default:    tmr_load_val = T_CLEAR;
    endcase
    flash_load = (nxt == NIGHT) && ((state != NIGHT) || flash_exp);
  end

`ifdef TRAFFIC_WALK_COUNTDOWN_EN
  logic [CNT_W-1:0] tmr_next;
  always_comb begin
    if (tmr_load)            tmr_next = tmr_load_val;
    else if (tmr_val != '0)  tmr_next = tmr_val - 1'b1;
    else                     tmr_next = '0;
  end
`endif

  logic unused_timer_bits;
  assign unused_timer_bits = ^{tmr_val, flash_val};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= B_CLR;
      last_phase    <= PHASE_B;
      ped_pending   <= 1'b0;
      bus.light_out <= '0;
      bus.walk_out  <= '0;
      bus.flash_out <= 1'b0;
      bus.mode      <= MODE_DAY;
`ifdef TRAFFIC_WALK_COUNTDOWN_EN
      bus.walk_remaining <= '0;
`endif
    end else begin
      state <= nxt;

      // last_phase is recorded only when a green runs to completion, so a
      // preempted green is re-served afterwards. Leaving NIGHT forces A next.
      if (state == A_GO && nxt == A_CLR) begin
        last_phase <= PHASE_A;
      end else if ((state == B_GO || state == NIGHT) && nxt == B_CLR) begin
        last_phase <= PHASE_B;
      end

      if (nxt == PED_WALK && state != PED_WALK) begin
        ped_pending <= 1'b0;
      end else if (bus.ped_signal) begin
        ped_pending <= 1'b1;
      end

      case (nxt)
        A_GO:    bus.light_out <= LOW_MASK;
        B_GO:    bus.light_out <= HIGH_MASK;
        // emg_lane is captured on EMG entry and then held.
        EMG:     bus.light_out <= (state == EMG) ? bus.light_out : bus.emg_lane;
        default: bus.light_out <= '0;
      endcase

      bus.walk_out <= (nxt == PED_WALK) ? '1 : '0;

      if (nxt != NIGHT) begin
        bus.flash_out <= 1'b0;
      end else if (state != NIGHT) begin
        bus.flash_out <= 1'b1;
      end else if (flash_exp) begin
        bus.flash_out <= ~bus.flash_out;
      end

      bus.mode <= mode_of(nxt);

`ifdef TRAFFIC_WALK_COUNTDOWN_EN
      bus.walk_remaining <= (nxt == PED_WALK) ? tmr_next : '0;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
`timescale 1ns/1ps
module tb_traffic_phase_controller;

  localparam int unsigned LANES = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  traffic_phase_controller_if #(.LANES(LANES)) bus ();

  traffic_phase_controller #(
    .LANES        (LANES),
    .CNT_W        (8),
    .GREEN_CYCLES (16),
    .CLEAR_CYCLES (4),
    .WALK_CYCLES  (12),
    .FLASH_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] light;
    logic [7:0] walk;
    logic       flash;
    logic [1:0] mode;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check_now(input exp_t e);
    checks++;
    if (bus.light_out !== e.light || bus.walk_out !== e.walk ||
        bus.flash_out !== e.flash || bus.mode !== e.mode) begin
      fails++;
      $display("FAIL %s @%0t: got light=%h walk=%h flash=%b mode=%0d, want light=%h walk=%h flash=%b mode=%0d",
               e.tag, $time, bus.light_out, bus.walk_out, bus.flash_out, bus.mode,
               e.light, e.walk, e.flash, e.mode);
    end
  endtask

  // Monitor: each entry describes the outputs after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_now(e);
      end
    end
  end

  // Called at a falling edge with inputs already set; pushes n cycles of
  // expected outputs and returns at the falling edge after the last one.
  task automatic expect_n(input int n, input logic [7:0] l, input logic [7:0] w,
                          input logic f, input logic [1:0] m, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.light = l; e.walk = w; e.flash = f; e.mode = m;
      e.tag   = $sformatf("%s[%0d]", tag, i);
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  // From a falling edge with rst low: one cycle held in reset, release, then
  // B_CLR finishes its 4 cycles and a full A/B cycle follows.
  task automatic reset_run(input string tag);
    expect_n(1, 8'h00, 8'h00, 1'b0, 2'd3, {tag, "_rst"});
    rst = 1'b1;
    expect_n(3,  8'h00, 8'h00, 1'b0, 2'd3, {tag, "_boot_clr"});
    expect_n(16, 8'h0F, 8'h00, 1'b0, 2'd3, {tag, "_a_go"});
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd3, {tag, "_a_clr"});
    expect_n(16, 8'hF0, 8'h00, 1'b0, 2'd3, {tag, "_b_go"});
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd3, {tag, "_b_clr"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d, want 0", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    bus.time_signal = 1'b0;
    bus.ped_signal  = 1'b0;
    bus.emg_signal  = 1'b0;
    bus.emg_lane    = '0;
    rst             = 1'b0;
    @(negedge clk);

    // Power-up sequence.
    reset_run("boot");

    // Pedestrian pulse on cycle 5 of A_GO: green not shortened.
    expect_n(4,  8'h0F, 8'h00, 1'b0, 2'd3, "ped_a_go_pre");
    bus.ped_signal = 1'b1;
    expect_n(1,  8'h0F, 8'h00, 1'b0, 2'd3, "ped_a_go_pulse");
    bus.ped_signal = 1'b0;
    expect_n(11, 8'h0F, 8'h00, 1'b0, 2'd3, "ped_a_go_post");
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd3, "ped_a_clr");
    expect_n(12, 8'h00, 8'hFF, 1'b0, 2'd1, "ped_walk");
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd1, "ped_clr");
    expect_n(3,  8'hF0, 8'h00, 1'b0, 2'd3, "ped_b_go");

    // Emergency preempts B_GO; lane changes during EMG are ignored.
    bus.emg_signal = 1'b1;
    bus.emg_lane   = 8'h08;
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd0, "emg_pre_clr");
    expect_n(1,  8'h08, 8'h00, 1'b0, 2'd0, "emg_hold_a");
    bus.emg_lane   = 8'h40;
    expect_n(5,  8'h08, 8'h00, 1'b0, 2'd0, "emg_hold_b");
    bus.emg_signal = 1'b0;
    bus.emg_lane   = '0;
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd0, "emg_clr");
    expect_n(7,  8'hF0, 8'h00, 1'b0, 2'd3, "emg_b_resume");

    // Night request during B_GO: green completes, B_CLR, then NIGHT.
    bus.time_signal = 1'b1;
    expect_n(9,  8'hF0, 8'h00, 1'b0, 2'd3, "night_b_go");
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd3, "night_b_clr");
    expect_n(8,  8'h00, 8'h00, 1'b1, 2'd2, "night_flash_on");
    expect_n(8,  8'h00, 8'h00, 1'b0, 2'd2, "night_flash_off");
    expect_n(4,  8'h00, 8'h00, 1'b1, 2'd2, "night_flash_on2");
    bus.time_signal = 1'b0;
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd3, "night_exit_clr");
    expect_n(16, 8'h0F, 8'h00, 1'b0, 2'd3, "night_a_go");

    // Emergency and pedestrian together during A_CLR: EMG first, walk after.
    expect_n(1,  8'h00, 8'h00, 1'b0, 2'd3, "both_a_clr_pre");
    bus.emg_signal = 1'b1;
    bus.ped_signal = 1'b1;
    bus.emg_lane   = 8'h20;
    expect_n(1,  8'h00, 8'h00, 1'b0, 2'd3, "both_a_clr_req");
    bus.ped_signal = 1'b0;
    expect_n(2,  8'h00, 8'h00, 1'b0, 2'd3, "both_a_clr_post");
    expect_n(5,  8'h20, 8'h00, 1'b0, 2'd0, "both_emg");
    bus.emg_signal = 1'b0;
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd0, "both_emg_clr");
    expect_n(12, 8'h00, 8'hFF, 1'b0, 2'd1, "both_walk");
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd1, "both_ped_clr");
    expect_n(3,  8'hF0, 8'h00, 1'b0, 2'd3, "both_b_go");

    // Asynchronous reset in the middle of EMG.
    bus.emg_signal = 1'b1;
    bus.emg_lane   = 8'h02;
    expect_n(4,  8'h00, 8'h00, 1'b0, 2'd0, "arst_pre_clr");
    expect_n(3,  8'h02, 8'h00, 1'b0, 2'd0, "arst_emg");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    r.light = 8'h00; r.walk = 8'h00; r.flash = 1'b0; r.mode = 2'd3; r.tag = "arst_immediate";
    check_now(r);
    bus.emg_signal = 1'b0;
    bus.emg_lane   = '0;
    @(negedge clk);
    reset_run("restart");

    // Drain: every queued expectation must have been compared.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
